// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the fetch PC, buffers {pc, instruction} pairs
// in a small prefetch queue and hands them to ID. Optional macro: FETCH_PERF_CNT_EN.
module fetch_queue_unit #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned PC_STEP = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [ADDR_W-1:0]         imem_addr,
  input  logic [INST_W-1:0]         imem_rdata,
  input  logic                      branch_taken,
  input  logic [ADDR_W-1:0]         branch_addr,
  input  logic                      id_ready,
  output logic                      if_valid,
  output logic [ADDR_W-1:0]         pc_out,
  output logic [INST_W-1:0]         instruction_out,
  output logic [$clog2(QDEPTH):0]   q_count
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]               fetch_cnt,
  output logic [31:0]               flush_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(STEP - ADDR_W'(1));
  localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(QDEPTH);

  logic [ADDR_W-1:0] fetch_pc;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] pc_mem   [QDEPTH];
  logic [INST_W-1:0] inst_mem [QDEPTH];

  logic push;
  logic pop;

  // A redirect suppresses both queue operations; push looks at the pre-pop count,
  // so a full queue being drained refills only on the following cycle.
  always_comb begin
    push = (count < FULL_CNT) && !branch_taken;
    pop  = (count != '0) && id_ready && !branch_taken;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (branch_taken) begin
      fetch_pc <= branch_addr & ALIGN_MASK;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + STEP;
        wr_ptr   <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; entries are only observable once
  // count covers them, so clearing the pointers is enough to discard them.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= fetch_pc;
      inst_mem[wr_ptr] <= imem_rdata;
    end
  end

  // NOTE: every output gets a default first so this block can never infer a latch.
  always_comb begin
    imem_addr       = fetch_pc;
    q_count         = count;
    if_valid        = 1'b0;
    pc_out          = '0;
    instruction_out = '0;
    if (count != '0) begin
      if_valid        = 1'b1;
      pc_out          = pc_mem[rd_ptr] + STEP;
      instruction_out = inst_mem[rd_ptr];
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Flushes are only counted when a redirect actually discards queued entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (push) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (branch_taken && (count != '0)) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: directed startup/backpressure/redirect
// scenarios plus random traffic, all compared against a queue-based reference model.
module tb_fetch_queue_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        id_ready;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic [2:0]  q_count;

  logic        rst_w;
  logic [31:0] imem_addr_w;
  logic [31:0] imem_rdata_w;
  logic        if_valid_w;
  logic [31:0] pc_out_w;
  logic [31:0] instruction_out_w;
  logic [2:0]  q_count_w;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, flush_cnt, fetch_cnt_w, flush_cnt_w;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: architectural fetch PC plus a plain queue of fetched PCs.
  logic [31:0] m_fpc;
  logic [31:0] m_q[$];
  logic [31:0] m_fetch;
  logic [31:0] m_flush;

  always #5 clk = ~clk;

  assign imem_rdata   = imem_addr ^ 32'hE000_0000;
  assign imem_rdata_w = imem_addr_w ^ 32'hE000_0000;

  fetch_queue_unit dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .branch_taken(branch_taken), .branch_addr(branch_addr), .id_ready(id_ready),
    .if_valid(if_valid), .pc_out(pc_out), .instruction_out(instruction_out),
    .q_count(q_count)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
`endif
  );

  fetch_queue_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst_w), .imem_addr(imem_addr_w), .imem_rdata(imem_rdata_w),
    .branch_taken(1'b0), .branch_addr(32'h0), .id_ready(1'b1),
    .if_valid(if_valid_w), .pc_out(pc_out_w), .instruction_out(instruction_out_w),
    .q_count(q_count_w)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt_w), .flush_cnt(flush_cnt_w)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    logic        v;
    logic [31:0] head;
    v    = (m_q.size() != 0);
    head = v ? m_q[0] : 32'h0;
    check("m_valid", 32'(if_valid), 32'(v));
    check("m_count", 32'(q_count), 32'(m_q.size()));
    check("m_addr", imem_addr, m_fpc);
    check("m_pc_out", pc_out, v ? head + 32'd4 : 32'h0);
    check("m_inst", instruction_out, v ? head ^ 32'hE000_0000 : 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("m_fetch_cnt", fetch_cnt, m_fetch);
    check("m_flush_cnt", flush_cnt, m_flush);
`endif
  endtask

  // Apply one cycle of inputs, advance the model by the rules, then compare #1 after the edge.
  task automatic step(input logic r, input logic b, input logic [31:0] ba, input logic rdy);
    int sz;
    rst = r; branch_taken = b; branch_addr = ba; id_ready = rdy;
    sz = m_q.size();
    if (r) begin
      m_q.delete(); m_fpc = 32'h0; m_fetch = 0; m_flush = 0;
    end else if (b) begin
      if (sz != 0) m_flush++;
      m_q.delete();
      m_fpc = {ba[31:2], 2'b00};
    end else begin
      if (sz > 0 && rdy) void'(m_q.pop_front());
      if (sz < 4) begin
        m_q.push_back(m_fpc);
        m_fpc = m_fpc + 32'd4;
        m_fetch++;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; rst_w = 1'b1; branch_taken = 1'b0; branch_addr = '0; id_ready = 1'b1;
    m_fpc = 0; m_fetch = 0; m_flush = 0;

    // Reset / startup, with the wrap instance released at the same time.
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    check("rst_valid", 32'(if_valid), 0);
    check("rst_count", 32'(q_count), 0);
    check("rst_addr", imem_addr, 32'h0);
    check("wrap_addr0", imem_addr_w, 32'hFFFF_FFF8);
    rst_w = 1'b0;
    step(0, 0, 0, 1);
    check("start_valid", 32'(if_valid), 1);
    check("start_inst", instruction_out, 32'hE000_0000);
    check("start_pc", pc_out, 32'h4);
    check("wrap_addr1", imem_addr_w, 32'hFFFF_FFFC);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1);
      check("stream_pc", pc_out, 32'h8 + 32'(i) * 4);
      if (i == 0) begin
        check("wrap_addr2", imem_addr_w, 32'h0);
        check("wrap_pc_out", pc_out_w, 32'h0);
      end
      if (i == 1) check("wrap_addr3", imem_addr_w, 32'h4);
    end

    // Backpressure: fill to 4 and hold, then drain in order.
    step(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    check("bp_full", 32'(q_count), 4);
    check("bp_addr_hold", imem_addr, 32'h10);
    check("bp_head", pc_out, 32'h4);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1);
      check("bp_drain_pc", pc_out, 32'h8 + 32'(i) * 4);
    end

    // Redirect in a steady stream.
    step(0, 0, 0, 1);
    step(0, 1, 32'h100, 1);
    check("br_valid", 32'(if_valid), 0);
    check("br_addr", imem_addr, 32'h100);
    step(0, 0, 0, 1);
    check("br_tgt_valid", 32'(if_valid), 1);
    check("br_tgt_pc", pc_out, 32'h104);
    check("br_tgt_inst", instruction_out, 32'hE000_0100);

    // Redirect while full and popping; target low bits are dropped.
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    check("fullbr_pre", 32'(q_count), 4);
    step(0, 1, 32'h203, 1);
    check("fullbr_count", 32'(q_count), 0);
    check("fullbr_addr", imem_addr, 32'h200);
    step(0, 0, 0, 0);
    check("fullbr_head", pc_out, 32'h204);

    // Reset wins over a simultaneous redirect.
    step(0, 1, 32'h40, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    check("rstbr_pre", 32'(q_count), 3);
    step(1, 1, 32'h500, 1);
    check("rstbr_count", 32'(q_count), 0);
    check("rstbr_addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("rstbr_fetch_cnt", fetch_cnt, 32'h0);
    check("rstbr_flush_cnt", flush_cnt, 32'h0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(49) == 0), ($urandom_range(9) == 0), $urandom, $urandom_range(1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
